cr_prefix_fe_ctlr: RTL and testbench
====================================

Name: cr_prefix_fe_ctlr

Overview:
Upstream control stage for the prefix feature-extraction counter array. It accepts the 8-byte-wide character stream of one compression block and partitions it into 1 KB windows (up to four per block). It drives the per-lane character/valid buses, the window select, and a dedicated end-of-window strobe cycle, so the downstream counters capture one count per window. Bytes beyond the last window are accepted but masked out of feature counting.

Parameters:
WIN_BYTES, 1024, bytes per feature window (power of two, ≥16).
NUM_WIN, 4, windows per block; fe_sel_1k is 2 bits wide, so NUM_WIN ≤ 4.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  64  characters, byte i = in_data[8i+7:8i]
in_vbytes  in  8  per-byte valid; contiguous from bit 0, nonzero unless in_eob
in_eob  in  1  last word of block (in_vbytes may be 0)
fe_char_in  out  64  registered characters to counter lanes
fe_char_vbytes  out  8  registered per-lane valid
fe_ctlr_eodb  out  1  end-of-window strobe (vbytes = 0 in that cycle)
fe_sel_1k  out  2  current window index 0..NUM_WIN-1
fe_done  out  1  one-cycle pulse after the final eodb of a block
fe_num_win  out  3  windows closed in the finished block, valid with fe_done

Behaviour:
- Reset (rst_n = 0 at posedge): all outputs 0 except in_ready, which is 0 during reset and 1 from the first cycle after reset. Byte count = 0, window = 0, state = PASS. Reset mid-block drops the block; no eodb or done is issued.
- All fe_* outputs are registered. Latency is 1 cycle from accept to fe_char_*.
- There is no downstream backpressure.
- State PASS, in_ready = 1. On accept, n = popcount(in_vbytes) and cnt is the byte count in the current window.
  - cnt + n < WIN_BYTES: emit word as-is, cnt += n.
  - cnt + n == WIN_BYTES: emit word, next state EODB, cnt = 0.
  - cnt + n > WIN_BYTES: emit the low (WIN_BYTES − cnt) lanes only. Hold the word and the remaining mask (in_vbytes & ~lowmask) and in_eob. Next state EODB, then SPLIT.
  - in_eob with cnt + n < WIN_BYTES: emit word, then EODB if cnt + n > 0, else go directly to DONE.
- State EODB, in_ready = 0: fe_ctlr_eodb = 1, fe_char_vbytes = 0, fe_sel_1k holds the closing window. Then window += 1.
  - Next state: SPLIT if a remainder is held; DONE if eob; MASK if window == NUM_WIN; else PASS.
- State SPLIT, in_ready = 0: emit the held word in its original lanes with the remaining mask, cnt = popcount(remainder).
  - The held eob leads to EODB then DONE.
  - If window == NUM_WIN, the remainder is emitted with vbytes = 0 and the next state is MASK, or DONE if eob.
- State MASK, in_ready = 1: accept words with fe_char_vbytes = 0. Go to DONE on eob, with no eodb.
- State DONE, in_ready = 0: fe_done = 1, fe_num_win = windows closed (0..NUM_WIN). Reset cnt and window to 0, go to PASS.
- fe_sel_1k saturates at NUM_WIN−1 in MASK.
- A block ending exactly on a window boundary issues a single eodb, never an extra empty one.
- fe_char_in keeps the last value when lanes are invalid.

Optional Feature:
CR_PREFIX_FE_CTLR_STATS_EN.
- Defined: adds outputs fe_blk_bytes[15:0] (saturating count of all accepted valid bytes in the block, including MASK bytes) and fe_vbytes_err (sticky until fe_done). fe_vbytes_err sets if an accepted in_vbytes is non-contiguous, or is 0 without eob. Both are valid with fe_done and cleared after.
- Undefined: the ports and logic are absent.

Test Plan:
- 128 full words (1024 B) plus eob on the last word → one eodb with sel = 0, fe_done with fe_num_win = 1, no extra eodb.
- cnt = 1020, accept a word with vbytes = 8'hFF → out vbytes 8'h0F; then an eodb cycle (sel 0); then vbytes 8'hF0 (sel 1); cnt = 4; in_ready low for 2 cycles.
- 5000 B block of full words → eodb at sel 0,1,2,3. Bytes 4097–5000 emitted with vbytes = 0. fe_num_win = 4.
- Block of a single word with vbytes 8'h07 and eob → data cycle, eodb (sel 0), done with fe_num_win = 1. An empty eob word alone → done with fe_num_win = 0, no eodb.
- Assert rst_n low while in SPLIT → next cycle all outputs 0, no eodb or done. A fresh block restarts at sel 0.
- STATS_EN: inject vbytes 8'h05 → fe_vbytes_err = 1 at fe_done. For a 5000 B block, fe_blk_bytes = 5000.

Source files
------------

// File: rtl/cr_prefix_fe_ctlr.sv
// Front-end controller for the prefix feature counters: splits a block's byte stream into windows.
// Optional CR_PREFIX_FE_CTLR_STATS_EN adds per-block byte count and vbytes error outputs.
module cr_prefix_fe_ctlr #(
    parameter int unsigned WIN_BYTES = 1024,
    parameter int unsigned NUM_WIN   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_vbytes,
    input  logic        in_eob,
    output logic [63:0] fe_char_in,
    output logic [7:0]  fe_char_vbytes,
    output logic        fe_ctlr_eodb,
    output logic [1:0]  fe_sel_1k,
    output logic        fe_done,
    output logic [2:0]  fe_num_win
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    ,
    output logic [15:0] fe_blk_bytes,
    output logic        fe_vbytes_err
`endif
);

    localparam int unsigned CW = $clog2(WIN_BYTES) + 1;
    localparam logic [CW-1:0] WinBytesC = CW'(WIN_BYTES);
    localparam logic [2:0]    NumWinC   = 3'(NUM_WIN);
    localparam logic [1:0]    LastSelC  = 2'(NUM_WIN - 1);

    typedef enum logic [2:0] {StPass, StEodb, StSplit, StMask, StDone} state_e;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    win_q, win_d;
    logic [63:0]   hold_q, hold_d;
    logic [7:0]    rem_q, rem_d;
    logic          eob_q, eob_d;
    logic          in_ready_q, in_ready_d;
    logic [63:0]   char_q, char_d;
    logic [7:0]    vb_q, vb_d;
    logic          eodb_q, eodb_d;
    logic [1:0]    sel_q, sel_d;
    logic          done_q, done_d;
    logic [2:0]    nw_q, nw_d;

    logic          accept;
    logic [3:0]    n_in;
    logic [CW-1:0] sum;
    logic [CW-1:0] room;
    logic [7:0]    lowmask;
    logic [1:0]    sel_cur;
    logic [7:0]    emit_mask;
    logic [63:0]   emit_data;

    assign accept  = in_valid & in_ready_q;
    assign n_in    = popcnt8(in_vbytes);
    assign sum     = cnt_q + CW'(n_in);
    assign room    = WinBytesC - cnt_q;
    assign sel_cur = (win_q >= NumWinC) ? LastSelC : win_q[1:0];

    // Lanes that still fit in the current window.
    always_comb begin
        lowmask = '0;
        for (int i = 0; i < 8; i++) begin
            lowmask[i] = (CW'(i) < room);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        hold_d    = hold_q;
        rem_d     = rem_q;
        eob_d     = eob_q;
        emit_mask = '0;
        emit_data = in_data;
        eodb_d    = 1'b0;
        sel_d     = sel_cur;
        done_d    = 1'b0;
        nw_d      = '0;

        case (state_q)
            StPass: begin
                if (accept) begin
                    if (sum > WinBytesC) begin
                        emit_mask = in_vbytes & lowmask;
                        hold_d    = in_data;
                        rem_d     = in_vbytes & ~lowmask;
                        eob_d     = in_eob;
                        cnt_d     = '0;
                        state_d   = StEodb;
                    end else if (sum == WinBytesC) begin
                        emit_mask = in_vbytes;
                        eob_d     = in_eob;
                        cnt_d     = '0;
                        state_d   = StEodb;
                    end else begin
                        emit_mask = in_vbytes;
                        cnt_d     = sum;
                        if (in_eob) begin
                            eob_d   = 1'b1;
                            // An empty block closes no window.
                            state_d = (sum != '0) ? StEodb : StDone;
                        end
                    end
                end
            end
            StEodb: begin
                eodb_d = 1'b1;
                win_d  = win_q + 3'd1;
                if (rem_q != '0) begin
                    state_d = StSplit;
                end else if (eob_q) begin
                    state_d = StDone;
                end else if (win_q + 3'd1 == NumWinC) begin
                    state_d = StMask;
                end else begin
                    state_d = StPass;
                end
            end
            StSplit: begin
                emit_data = hold_q;
                rem_d     = '0;
                if (win_q >= NumWinC) begin
                    state_d = eob_q ? StDone : StMask;
                end else begin
                    emit_mask = rem_q;
                    cnt_d     = CW'(popcnt8(rem_q));
                    state_d   = eob_q ? StEodb : StPass;
                end
            end
            StMask: begin
                if (accept && in_eob) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                nw_d    = win_q;
                cnt_d   = '0;
                win_d   = '0;
                eob_d   = 1'b0;
                sel_d   = '0;
                state_d = StPass;
            end
            default: state_d = StPass;
        endcase

        in_ready_d = (state_d == StPass) || (state_d == StMask);
        vb_d       = emit_mask;
        // Invalid lanes keep their previous character.
        for (int i = 0; i < 8; i++) begin
            char_d[8*i +: 8] = emit_mask[i] ? emit_data[8*i +: 8] : char_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StPass;
            cnt_q      <= '0;
            win_q      <= '0;
            hold_q     <= '0;
            rem_q      <= '0;
            eob_q      <= 1'b0;
            in_ready_q <= 1'b0;
            char_q     <= '0;
            vb_q       <= '0;
            eodb_q     <= 1'b0;
            sel_q      <= '0;
            done_q     <= 1'b0;
            nw_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            hold_q     <= hold_d;
            rem_q      <= rem_d;
            eob_q      <= eob_d;
            in_ready_q <= in_ready_d;
            char_q     <= char_d;
            vb_q       <= vb_d;
            eodb_q     <= eodb_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            nw_q       <= nw_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign fe_char_in     = char_q;
    assign fe_char_vbytes = vb_q;
    assign fe_ctlr_eodb   = eodb_q;
    assign fe_sel_1k      = sel_q;
    assign fe_done        = done_q;
    assign fe_num_win     = nw_q;

`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    logic [15:0] blk_q, blk_d, blk_base;
    logic [16:0] blk_sum;
    logic        err_q, err_d, err_base;
    logic        vb_bad;

    // Contiguous-from-bit-0 masks satisfy v & (v + 1) == 0.
    assign vb_bad = ((in_vbytes & (in_vbytes + 8'd1)) != 8'd0) || ((in_vbytes == 8'd0) && !in_eob);

    // Totals are presented alongside fe_done and cleared on the following edge.
    always_comb begin
        blk_base = done_q ? 16'd0 : blk_q;
        err_base = done_q ? 1'b0 : err_q;
        blk_sum  = {1'b0, blk_base} + 17'(n_in);
        blk_d    = blk_base;
        err_d    = err_base;
        if (accept) begin
            blk_d = blk_sum[16] ? 16'hFFFF : blk_sum[15:0];
            err_d = err_base | vb_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_q <= '0;
            err_q <= 1'b0;
        end else begin
            blk_q <= blk_d;
            err_q <= err_d;
        end
    end

    assign fe_blk_bytes  = blk_q;
    assign fe_vbytes_err = err_q;
`endif

endmodule

// File: tb/tb_cr_prefix_fe_ctlr.sv
// Directed bench for cr_prefix_fe_ctlr; stats checks compile in with CR_PREFIX_FE_CTLR_STATS_EN.
module tb_cr_prefix_fe_ctlr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_vbytes;
    logic        in_eob;
    logic [63:0] fe_char_in;
    logic [7:0]  fe_char_vbytes;
    logic        fe_ctlr_eodb;
    logic [1:0]  fe_sel_1k;
    logic        fe_done;
    logic [2:0]  fe_num_win;
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
    logic [15:0] fe_blk_bytes;
    logic        fe_vbytes_err;
`endif

    always #5 clk = ~clk;

    cr_prefix_fe_ctlr dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_vbytes      (in_vbytes),
        .in_eob         (in_eob),
        .fe_char_in     (fe_char_in),
        .fe_char_vbytes (fe_char_vbytes),
        .fe_ctlr_eodb   (fe_ctlr_eodb),
        .fe_sel_1k      (fe_sel_1k),
        .fe_done        (fe_done),
        .fe_num_win     (fe_num_win)
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        ,
        .fe_blk_bytes   (fe_blk_bytes),
        .fe_vbytes_err  (fe_vbytes_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Event log, sampled on the falling edge.
    int         eodb_cnt = 0;
    int         done_cnt = 0;
    int         vb_sum   = 0;
    logic [1:0] eodb_sels[$];
    logic [2:0] last_nw  = '0;
    logic [15:0] last_blk = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            vb_sum = vb_sum + $countones(fe_char_vbytes);
            if (fe_ctlr_eodb) begin
                eodb_cnt = eodb_cnt + 1;
                eodb_sels.push_back(fe_sel_1k);
            end
            if (fe_done) begin
                done_cnt = done_cnt + 1;
                last_nw  = fe_num_win;
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
                last_blk = fe_blk_bytes;
                last_err = fe_vbytes_err;
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the word until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [7:0] vb, input logic e);
        bit acc;
        int k;
        in_valid  = 1'b1;
        in_data   = d;
        in_vbytes = vb;
        in_eob    = e;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 32) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!acc) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int d0, input string nm);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 50) begin
            tick(1);
            k++;
        end
        chk(nm, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic fill_1020();
        for (int i = 0; i < 127; i++) send(64'h0101010101010101 * 64'(i + 1), 8'hFF, 1'b0);
        send(64'h0, 8'h0F, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  vb;
        logic        eob;
        logic [63:0] e_d;
        logic [7:0]  e_vb;
        logic        e_eodb;
        logic [1:0]  e_sel;
        logic        e_done;
        logic [2:0]  e_nw;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[10];

    localparam logic [63:0] D1 = 64'h0807060504030201;
    localparam logic [63:0] D2 = 64'h1122334455667788;
    localparam logic [63:0] D3 = 64'hAAAABBBBCCCCDDDD;
    localparam logic [63:0] DS = 64'hF0E1D2C3B4A59687;

    initial begin
        int e0, d0, v0;
        logic [63:0] tmp;

        // Single 3-byte block, empty block, then a 10-byte block.
        tbl[0] = '{1'b1, D1,    8'h07, 1'b1, 64'h0000000000030201, 8'h07, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h0000000000030201, 8'h00, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[2] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h0000000000030201, 8'h00, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1};
        tbl[3] = '{1'b1, 64'hDEAD, 8'h00, 1'b1, 64'h0000000000030201, 8'h00, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[4] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h0000000000030201, 8'h00, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1};
        tbl[5] = '{1'b1, D2,    8'hFF, 1'b0, D2,                   8'hFF, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};
        tbl[6] = '{1'b1, D3,    8'h03, 1'b1, 64'h112233445566DDDD, 8'h03, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[7] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h112233445566DDDD, 8'h00, 1'b1, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[8] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h112233445566DDDD, 8'h00, 1'b0, 2'd0, 1'b1, 3'd1, 1'b1};
        tbl[9] = '{1'b0, 64'h0, 8'h00, 1'b0, 64'h112233445566DDDD, 8'h00, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_vbytes = '0;
        in_eob    = 1'b0;

        // Reset state
        tick(2);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_char", fe_char_in, 64'd0);
        chk("rst_vb", 64'(fe_char_vbytes), 64'd0);
        chk("rst_eodb", 64'(fe_ctlr_eodb), 64'd0);
        chk("rst_sel", 64'(fe_sel_1k), 64'd0);
        chk("rst_done", 64'(fe_done), 64'd0);
        chk("rst_nw", 64'(fe_num_win), 64'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        for (int r = 0; r < 10; r++) begin
            in_valid  = tbl[r].v;
            in_data   = tbl[r].d;
            in_vbytes = tbl[r].vb;
            in_eob    = tbl[r].eob;
            tick(1);
            chk($sformatf("row%0d_char", r), fe_char_in, tbl[r].e_d);
            chk($sformatf("row%0d_vb", r), 64'(fe_char_vbytes), 64'(tbl[r].e_vb));
            chk($sformatf("row%0d_eodb", r), 64'(fe_ctlr_eodb), 64'(tbl[r].e_eodb));
            chk($sformatf("row%0d_sel", r), 64'(fe_sel_1k), 64'(tbl[r].e_sel));
            chk($sformatf("row%0d_done", r), 64'(fe_done), 64'(tbl[r].e_done));
            chk($sformatf("row%0d_nw", r), 64'(fe_num_win), 64'(tbl[r].e_nw));
            chk($sformatf("row%0d_rdy", r), 64'(in_ready), 64'(tbl[r].e_rdy));
        end
        in_valid = 1'b0;

        // Exactly 1024 bytes: one eodb, no trailing empty window.
        e0 = eodb_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 127; i++) send(64'(i), 8'hFF, 1'b0);
        chk("b1k_no_early_eodb", 64'(eodb_cnt - e0), 64'd0);
        send(64'h77, 8'hFF, 1'b1);
        chk("b1k_last_vb", 64'(fe_char_vbytes), 64'hFF);
        chk("b1k_last_rdy", 64'(in_ready), 64'd0);
        tick(1);
        chk("b1k_eodb", 64'(fe_ctlr_eodb), 64'd1);
        chk("b1k_eodb_sel", 64'(fe_sel_1k), 64'd0);
        tick(1);
        chk("b1k_done", 64'(fe_done), 64'd1);
        chk("b1k_nw", 64'(fe_num_win), 64'd1);
        tick(3);
        chk("b1k_eodb_total", 64'(eodb_cnt - e0), 64'd1);
        chk("b1k_done_total", 64'(done_cnt - d0), 64'd1);

        // Word straddling the window boundary at cnt = 1020.
        fill_1020();
        send(DS, 8'hFF, 1'b0);
        chk("split_lo_vb", 64'(fe_char_vbytes), 64'h0F);
        tmp = fe_char_in;
        chk("split_lo_data", 64'(tmp[31:0]), 64'(DS[31:0]));
        chk("split_lo_sel", 64'(fe_sel_1k), 64'd0);
        chk("split_lo_rdy", 64'(in_ready), 64'd0);
        tick(1);
        chk("split_eodb", 64'(fe_ctlr_eodb), 64'd1);
        chk("split_eodb_vb", 64'(fe_char_vbytes), 64'd0);
        chk("split_eodb_sel", 64'(fe_sel_1k), 64'd0);
        chk("split_eodb_rdy", 64'(in_ready), 64'd0);
        tick(1);
        chk("split_hi_vb", 64'(fe_char_vbytes), 64'hF0);
        chk("split_hi_data", fe_char_in, DS);
        chk("split_hi_sel", 64'(fe_sel_1k), 64'd1);
        chk("split_hi_eodb", 64'(fe_ctlr_eodb), 64'd0);
        chk("split_hi_rdy", 64'(in_ready), 64'd1);
        d0 = done_cnt;
        send(64'h0, 8'h00, 1'b1);
        tick(1);
        chk("split_tail_eodb", 64'(fe_ctlr_eodb), 64'd1);
        chk("split_tail_sel", 64'(fe_sel_1k), 64'd1);
        wait_done(d0, "split_done");
        chk("split_nw", 64'(last_nw), 64'd2);

        // 5000-byte block: four windows, the rest masked.
        e0 = eodb_cnt;
        d0 = done_cnt;
        v0 = vb_sum;
        for (int i = 0; i < 624; i++) send(64'(i * 3), 8'hFF, 1'b0);
        send(64'h5, 8'hFF, 1'b1);
        wait_done(d0, "b5k_done");
        tick(1);
        chk("b5k_eodb_total", 64'(eodb_cnt - e0), 64'd4);
        for (int j = 0; j < 4; j++) chk($sformatf("b5k_sel%0d", j), 64'(eodb_sels[e0 + j]), 64'(j));
        chk("b5k_bytes_out", 64'(vb_sum - v0), 64'd4096);
        chk("b5k_nw", 64'(last_nw), 64'd4);
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        chk("b5k_blk_bytes", 64'(last_blk), 64'd5000);
        chk("b5k_err", 64'(last_err), 64'd0);
`endif

        // Reset while the split remainder is held.
        fill_1020();
        send(DS, 8'hFF, 1'b0);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("rsplit_char", fe_char_in, 64'd0);
        chk("rsplit_vb", 64'(fe_char_vbytes), 64'd0);
        chk("rsplit_eodb", 64'(fe_ctlr_eodb), 64'd0);
        chk("rsplit_sel", 64'(fe_sel_1k), 64'd0);
        chk("rsplit_done", 64'(fe_done), 64'd0);
        chk("rsplit_nw", 64'(fe_num_win), 64'd0);
        chk("rsplit_rdy", 64'(in_ready), 64'd0);
        e0 = eodb_cnt;
        d0 = done_cnt;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("rsplit_no_eodb", 64'(eodb_cnt - e0), 64'd0);
        chk("rsplit_no_done", 64'(done_cnt - d0), 64'd0);
        send(64'h55, 8'h01, 1'b1);
        chk("fresh_vb", 64'(fe_char_vbytes), 64'h01);
        tick(1);
        chk("fresh_eodb", 64'(fe_ctlr_eodb), 64'd1);
        chk("fresh_sel", 64'(fe_sel_1k), 64'd0);
        tick(1);
        chk("fresh_done", 64'(fe_done), 64'd1);
        chk("fresh_nw", 64'(fe_num_win), 64'd1);

        // Non-contiguous vbytes, then a clean block.
        d0 = done_cnt;
        send(64'h3344, 8'h05, 1'b1);
        wait_done(d0, "err_done");
        chk("err_nw", 64'(last_nw), 64'd1);
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        chk("err_flag", 64'(last_err), 64'd1);
        chk("err_blk_bytes", 64'(last_blk), 64'd2);
`endif
        d0 = done_cnt;
        send(64'h66, 8'h01, 1'b1);
        wait_done(d0, "clean_done");
`ifdef CR_PREFIX_FE_CTLR_STATS_EN
        chk("clean_err", 64'(last_err), 64'd0);
        chk("clean_blk_bytes", 64'(last_blk), 64'd1);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
